node_superpos_seq: RTL and testbench
====================================

// Module: node_superpos_seq
// PURPOSE
//  Superposition (composition) sequencer: computes RES = f(g0(IN0,IN1), g1(IN0,IN1)).
//  Sits directly upstream of a primitive-recursion node. Its F_* port group drives that
//  node's ST/IN0/IN1 and consumes its RD/RES.
//  Children (g0, g1, f) are external generated nodes using the ST/RD level handshake.
//  Adds an ack/done timeout so a hung child raises ERR instead of stalling the tree.
// PARAMETERS
//  W      16     data width of IN*, RES, child args/results
//  TMO    1024   max cycles spent in any single wait state before ERR; TMO >= 2
//  TW     16     width of timeout counter; 2**TW > TMO
// PORTS
//  CLK     in   1   clock, all logic on posedge
//  RST     in   1   synchronous reset, active-high
//  ST      in   1   start request; a 0->1 transition starts a computation
//  RD      out  1   1 = idle/result valid; 0 = busy
//  RES     out  W   result, valid while RD=1 and ERR=0
//  ERR     out  1   1 = last run aborted by timeout; cleared on next accepted start
//  IN0     in   W   argument 0, sampled on accepted start
//  IN1     in   W   argument 1, sampled on accepted start
//  ARG0    out  W   latched IN0, drives IN0 of g0 and g1
//  ARG1    out  W   latched IN1, drives IN1 of g0 and g1
//  G0_ST   out  1   start to g0;  G0_RD in 1 ready from g0;  G0_RES in W result of g0
//  G1_ST   out  1   start to g1;  G1_RD in 1 ready from g1;  G1_RES in W result of g1
//  F_ST    out  1   start to f;   F_RD  in 1 ready from f;   F_RES  in W result of f
//  F_ARG0  out  W   latched G0_RES, drives f IN0
//  F_ARG1  out  W   latched G1_RES, drives f IN1
// BEHAVIOUR
//  Reset (sync): RD=1, RES=0, ERR=0, all *_ST=0, ARG*/F_ARG*=0, state IDLE, ST_old=0.
//  Start: accepted only in IDLE, when ST=1 and ST_old=0.
//   ST_old is registered every cycle, including in reset.
//   Same edge: latch ARG0/ARG1, RD=0, ERR=0, G0_ST=G1_ST=1, state G_ACK.
//   An ST edge while busy is ignored; no queueing.
//  Child handshake: child acks by dropping RD to 0 and completes by raising RD to 1.
//   Its result is taken on the edge where RD=1 is first seen after the ack.
//  Each child ST is held at 1 until that child's ack is sampled, then cleared.
//  States:
//   G_ACK:  track ack0/ack1 independently; clear G0_ST/G1_ST per ack.
//           Both acked -> G_DONE.
//   G_DONE: on first G0_RD=1 latch F_ARG0=G0_RES; same for g1 -> F_ARG1 (any order, or same cycle).
//           Both latched -> F_ST=1, state F_ACK.
//   F_ACK:  F_RD=0 sampled -> F_ST=0, state F_DONE.
//   F_DONE: F_RD=1 -> RES=F_RES, RD=1, state IDLE.
//  Latency: with zero-wait children (ack 1 cycle after ST, done 1 cycle after ack), RD returns
//   exactly 6 cycles after the accepting edge.
//  Timeout: counter clears on every state entry and increments each cycle in
//   G_ACK/G_DONE/F_ACK/F_DONE. Reaching TMO aborts:
//   all *_ST=0, RES=0, ERR=1, RD=1, state IDLE.
//   A child result arriving on the abort cycle is discarded.
//  A run completing on the same edge as a new ST rise: that ST edge is not accepted (must re-rise).
//  Reset mid-operation: immediate return to reset values; children are not otherwise notified.
//  No arithmetic on data. All data paths are W-bit register copies with no truncation.
// TESTING
//  1 Reset held 3 cycles mid-run -> RD=1, RES=0, ERR=0, all *_ST=0 on the cycle after RST.
//  2 g0=add, g1=sub, f=mul (1-cycle models), IN0=7, IN1=3 -> RES=40, ERR=0;
//    RD low exactly 6 cycles.
//  3 Same functions; g0 done 20 cycles after g1, then reversed order.
//    In both orders -> F_ARG0=10, F_ARG1=4 before F_ST rises, RES=40.
//  4 f never acks (F_RD stuck 1), TMO=16 -> ERR=1, RD=1, RES=0 after 16 cycles in F_ACK;
//    next start clears ERR.
//  5 ST toggled 0->1 twice while busy -> single run, one result; ARG0/ARG1 keep the first sampled values.
//  6 f = recursion node model, IN0=2, IN1=0xFFFF, g0=IN1, g1=IN0 -> RES matches model.
//    Checks full W-bit path with no truncation.

Source files
------------

// File: rtl/node_superpos_seq_if.sv
// Handshake/data bundle for the superposition sequencer.
// Upstream side : st, in0, in1 in; rd, res, err out.
// Child g0/g1   : g*_st out, g*_rd/g*_res in; arg0/arg1 out (shared by g0 and g1).
// Child f       : f_st out, f_rd/f_res in; f_arg0/f_arg1 out.
// slave modport is the sequencer's view; master is the environment's view.
interface node_superpos_seq_if #(
  parameter int W = 16
);
  logic         st;
  logic         rd;
  logic [W-1:0] res;
  logic         err;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic [W-1:0] arg0;
  logic [W-1:0] arg1;
  logic         g0_st;
  logic         g0_rd;
  logic [W-1:0] g0_res;
  logic         g1_st;
  logic         g1_rd;
  logic [W-1:0] g1_res;
  logic         f_st;
  logic         f_rd;
  logic [W-1:0] f_res;
  logic [W-1:0] f_arg0;
  logic [W-1:0] f_arg1;

  modport slave (
    input  st, in0, in1, g0_rd, g0_res, g1_rd, g1_res, f_rd, f_res,
    output rd, res, err, arg0, arg1, g0_st, g1_st, f_st, f_arg0, f_arg1
  );

  modport master (
    output st, in0, in1, g0_rd, g0_res, g1_rd, g1_res, f_rd, f_res,
    input  rd, res, err, arg0, arg1, g0_st, g1_st, f_st, f_arg0, f_arg1
  );
endinterface

// File: rtl/node_superpos_seq.sv
// Superposition sequencer: res = f(g0(in0,in1), g1(in0,in1)).
// Children use a level handshake: ack = rd drops to 0, done = rd rises to 1.
// A per-state timeout aborts a run with err=1 if a child hangs.
// Ports:
//   clk  in  clock, posedge
//   rst  in  synchronous reset, active-high
//   bus  node_superpos_seq_if.slave (upstream request/result, child g0/g1/f links)
//
// state  | meaning
// IDLE   | rd=1, waiting for an st rising edge
// G_ACK  | g0/g1 started, waiting for both acks
// G_DONE | both acked, collecting g0/g1 results into f_arg0/f_arg1
// F_ACK  | f started, waiting for its ack
// F_DONE | f acked, waiting for its result
module node_superpos_seq #(
  parameter int W   = 16,
  parameter int TMO = 1024,
  parameter int TW  = 16
) (
  input logic clk,
  input logic rst,
  node_superpos_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, G_ACK, G_DONE, F_ACK, F_DONE} state_t;

  // Down-counter loaded on every state entry; reaching zero while busy
  // means TMO cycles were spent in the current wait state.
  localparam logic [TW-1:0] TMO_LOAD = TW'(TMO - 1);

  state_t       state;
  logic         st_old;
  logic         rd;
  logic [W-1:0] res;
  logic         err;
  logic [W-1:0] arg0;
  logic [W-1:0] arg1;
  logic         g0_st;
  logic         g1_st;
  logic         f_st;
  logic [W-1:0] f_arg0;
  logic [W-1:0] f_arg1;
  logic         ack0;
  logic         ack1;
  logic         got0;
  logic         got1;
  logic [TW-1:0] tmo_cnt;

  logic start;
  logic tmo_hit;
  logic take0;
  logic take1;
  logic both_acked;
  logic both_got;

  assign start   = (state == IDLE) && bus.st && !st_old;
  assign tmo_hit = (state != IDLE) && (tmo_cnt == '0);

  // A child's result is taken on the first rd=1 seen after its ack, which can
  // already happen in G_ACK when the other child is slow to ack.
  assign take0      = ack0 && !got0 && bus.g0_rd;
  assign take1      = ack1 && !got1 && bus.g1_rd;
  assign both_acked = (ack0 || !bus.g0_rd) && (ack1 || !bus.g1_rd);
  assign both_got   = (got0 || take0) && (got1 || take1);

  always_ff @(posedge clk) begin
    st_old <= bus.st;
    if (rst) begin
      state   <= IDLE;
      rd      <= 1'b1;
      res     <= '0;
      err     <= 1'b0;
      arg0    <= '0;
      arg1    <= '0;
      g0_st   <= 1'b0;
      g1_st   <= 1'b0;
      f_st    <= 1'b0;
      f_arg0  <= '0;
      f_arg1  <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      got0    <= 1'b0;
      got1    <= 1'b0;
      tmo_cnt <= '0;
    end else if (tmo_hit) begin
      // Abort wins over any child event on this edge.
      state <= IDLE;
      g0_st <= 1'b0;
      g1_st <= 1'b0;
      f_st  <= 1'b0;
      res   <= '0;
      err   <= 1'b1;
      rd    <= 1'b1;
    end else begin
      if (state != IDLE) tmo_cnt <= tmo_cnt - TW'(1);
      case (state)
        IDLE: begin
          if (start) begin
            arg0    <= bus.in0;
            arg1    <= bus.in1;
            rd      <= 1'b0;
            err     <= 1'b0;
            g0_st   <= 1'b1;
            g1_st   <= 1'b1;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            got0    <= 1'b0;
            got1    <= 1'b0;
            tmo_cnt <= TMO_LOAD;
            state   <= G_ACK;
          end
        end
        G_ACK, G_DONE: begin
          if (!ack0 && !bus.g0_rd) begin
            ack0  <= 1'b1;
            g0_st <= 1'b0;
          end
          if (!ack1 && !bus.g1_rd) begin
            ack1  <= 1'b1;
            g1_st <= 1'b0;
          end
          if (take0) begin
            f_arg0 <= bus.g0_res;
            got0   <= 1'b1;
          end
          if (take1) begin
            f_arg1 <= bus.g1_res;
            got1   <= 1'b1;
          end
          if (state == G_ACK && both_acked) begin
            tmo_cnt <= TMO_LOAD;
            state   <= G_DONE;
          end else if (state == G_DONE && both_got) begin
            f_st    <= 1'b1;
            tmo_cnt <= TMO_LOAD;
            state   <= F_ACK;
          end
        end
        F_ACK: begin
          if (!bus.f_rd) begin
            f_st    <= 1'b0;
            tmo_cnt <= TMO_LOAD;
            state   <= F_DONE;
          end
        end
        F_DONE: begin
          if (bus.f_rd) begin
            res   <= bus.f_res;
            rd    <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd     = rd;
  assign bus.res    = res;
  assign bus.err    = err;
  assign bus.arg0   = arg0;
  assign bus.arg1   = arg1;
  assign bus.g0_st  = g0_st;
  assign bus.g1_st  = g1_st;
  assign bus.f_st   = f_st;
  assign bus.f_arg0 = f_arg0;
  assign bus.f_arg1 = f_arg1;

endmodule

// File: tb/tb_node_superpos_seq.sv
// Directed bench for node_superpos_seq with behavioural child nodes g0, g1, f.
// Child i: on st rising, waits ack_x[i] extra cycles before dropping rd, then
// done_x[i] extra cycles before raising rd with its result; mute ignores st.
module tb_node_superpos_seq;
  localparam int W   = 16;
  localparam int TMO = 16;
  localparam int TW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  node_superpos_seq_if #(.W(W)) bus ();

  node_superpos_seq #(.W(W), .TMO(TMO), .TW(TW)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // ---------------- child models ----------------
  int           fn_mode = 0;
  logic [2:0]   ch_st;
  logic [2:0]   ch_stp;
  logic         ch_rd   [3];
  logic [W-1:0] ch_res  [3];
  logic [W-1:0] ch_a    [3];
  logic [W-1:0] ch_b    [3];
  logic [1:0]   ch_ph   [3];
  int           ch_cnt  [3];
  int           ack_x   [3];
  int           done_x  [3];
  logic         ch_mute [3];

  function automatic logic [W-1:0] child_fn(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    if (fn_mode == 0) begin
      if (i == 0)      r = a + b;
      else if (i == 1) r = a - b;
      else             r = a * b;
    end else begin
      if (i == 0)      r = b;
      else if (i == 1) r = a;
      else begin
        // primitive-recursion model: h(x,0)=x, h(x,n+1)=h(x,n)-1
        r = a;
        for (int k = 0; k < int'(b); k++) r = r - 1'b1;
      end
    end
    return r;
  endfunction

  assign ch_st      = {bus.f_st, bus.g1_st, bus.g0_st};
  assign bus.g0_rd  = ch_rd[0];
  assign bus.g1_rd  = ch_rd[1];
  assign bus.f_rd   = ch_rd[2];
  assign bus.g0_res = ch_res[0];
  assign bus.g1_res = ch_res[1];
  assign bus.f_res  = ch_res[2];

  always @(posedge clk) begin
    ch_stp <= ch_st;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        ch_ph[i]  <= 2'd0;
        ch_rd[i]  <= 1'b1;
        ch_res[i] <= '0;
        ch_cnt[i] <= 0;
      end else begin
        case (ch_ph[i])
          2'd0: if (ch_st[i] && !ch_stp[i] && !ch_mute[i]) begin
            ch_a[i] <= (i == 2) ? bus.f_arg0 : bus.arg0;
            ch_b[i] <= (i == 2) ? bus.f_arg1 : bus.arg1;
            if (ack_x[i] == 0) begin
              ch_rd[i]  <= 1'b0;
              ch_ph[i]  <= 2'd2;
              ch_cnt[i] <= done_x[i];
            end else begin
              ch_ph[i]  <= 2'd1;
              ch_cnt[i] <= ack_x[i] - 1;
            end
          end
          2'd1: if (ch_cnt[i] == 0) begin
            ch_rd[i]  <= 1'b0;
            ch_ph[i]  <= 2'd2;
            ch_cnt[i] <= done_x[i];
          end else ch_cnt[i] <= ch_cnt[i] - 1;
          2'd2: if (ch_cnt[i] == 0) begin
            ch_rd[i]  <= 1'b1;
            ch_res[i] <= child_fn(i, ch_a[i], ch_b[i]);
            ch_ph[i]  <= 2'd0;
          end else ch_cnt[i] <= ch_cnt[i] - 1;
          default: ch_ph[i] <= 2'd0;
        endcase
      end
    end
  end

  // accepted-run counter: one g0_st rise per accepted start
  int   runs = 0;
  logic g0_st_q = 1'b0;
  always @(posedge clk) begin
    g0_st_q <= bus.g0_st;
    if (bus.g0_st && !g0_st_q) runs <= runs + 1;
  end

  // ---------------- helpers ----------------
  task automatic set_child(input int i, input int ax, input int dx);
    ack_x[i]  = ax;
    done_x[i] = dx;
  endtask

  task automatic do_run(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                        output logic [W-1:0] fa0, output logic [W-1:0] fa1,
                        output logic [W-1:0] mid0, output logic [W-1:0] mid1);
    bit seen_f;
    @(negedge clk);
    bus.st  = 1'b1;
    bus.in0 = a;
    bus.in1 = b;
    @(negedge clk);
    bus.st = 1'b0;
    lat    = 0;
    seen_f = 0;
    fa0 = '0; fa1 = '0; mid0 = '0; mid1 = '0;
    while (!bus.rd && lat < 200) begin
      if (bus.f_st && !seen_f) begin
        seen_f = 1;
        fa0 = bus.f_arg0;
        fa1 = bus.f_arg1;
      end
      if (lat == 8) begin
        mid0 = bus.f_arg0;
        mid1 = bus.f_arg1;
      end
      lat++;
      @(negedge clk);
    end
    chk("run_bounded", 32'(lat < 200), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    int r0;
    logic [W-1:0] fa0, fa1, mid0, mid1;

    bus.st = 1'b0; bus.in0 = '0; bus.in1 = '0;
    for (int i = 0; i < 3; i++) begin
      set_child(i, 0, 0);
      ch_mute[i] = 1'b0;
    end

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd",  32'(bus.rd), 32'd1);
    chk("rst_res", 32'(bus.res), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_st",  32'({bus.g0_st, bus.g1_st, bus.f_st}), 32'd0);
    chk("rst_arg", 32'({bus.arg0, bus.f_arg1}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic run: 7,3 -> (7+3)*(7-3) = 40, rd low 6 cycles
    do_run(16'd7, 16'd3, lat, fa0, fa1, mid0, mid1);
    chk("t2_res", 32'(bus.res), 32'd40);
    chk("t2_err", 32'(bus.err), 32'd0);
    chk("t2_lat", 32'(lat), 32'd6);
    chk("t2_fa0", 32'(fa0), 32'd10);
    chk("t2_fa1", 32'(fa1), 32'd4);

    // reset held 3 cycles mid-run
    @(negedge clk);
    bus.st = 1'b1; bus.in0 = 16'd9; bus.in1 = 16'd1;
    @(negedge clk);
    bus.st = 1'b0;
    @(negedge clk);
    chk("t1_busy", 32'(bus.rd), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("t1_rd",  32'(bus.rd), 32'd1);
    chk("t1_res", 32'(bus.res), 32'd0);
    chk("t1_err", 32'(bus.err), 32'd0);
    chk("t1_st",  32'({bus.g0_st, bus.g1_st, bus.f_st}), 32'd0);
    chk("t1_arg", 32'(bus.arg0), 32'd0);
    @(negedge clk);
    chk("t1_rd_after", 32'(bus.rd), 32'd1);

    // full-width path: g0=IN1, g1=IN0, f=recursion
    fn_mode = 1;
    do_run(16'd2, 16'hFFFF, lat, fa0, fa1, mid0, mid1);
    chk("t6_res",  32'(bus.res), 32'hFFFD);
    chk("t6_err",  32'(bus.err), 32'd0);
    chk("t6_arg1", 32'(bus.arg1), 32'hFFFF);
    chk("t6_fa0",  32'(fa0), 32'hFFFF);
    chk("t6_fa1",  32'(fa1), 32'd2);
    fn_mode = 0;

    // g0 done 20 cycles after g1 (delay split over ack and done to stay under TMO)
    set_child(0, 9, 11);
    do_run(16'd7, 16'd3, lat, fa0, fa1, mid0, mid1);
    chk("t3a_mid_fa1", 32'(mid1), 32'd4);
    chk("t3a_mid_fa0", 32'(mid0), 32'hFFFF);
    chk("t3a_fa0", 32'(fa0), 32'd10);
    chk("t3a_fa1", 32'(fa1), 32'd4);
    chk("t3a_res", 32'(bus.res), 32'd40);
    chk("t3a_lat", 32'(lat), 32'd26);

    // reversed: g1 done 20 cycles after g0
    set_child(0, 0, 0);
    set_child(1, 9, 11);
    do_run(16'd7, 16'd3, lat, fa0, fa1, mid0, mid1);
    chk("t3b_fa0", 32'(fa0), 32'd10);
    chk("t3b_fa1", 32'(fa1), 32'd4);
    chk("t3b_res", 32'(bus.res), 32'd40);
    chk("t3b_lat", 32'(lat), 32'd26);
    set_child(1, 0, 0);

    // f never acks -> abort after TMO cycles in F_ACK
    ch_mute[2] = 1'b1;
    @(negedge clk);
    bus.st = 1'b1; bus.in0 = 16'd7; bus.in1 = 16'd3;
    @(negedge clk);
    bus.st = 1'b0;
    cnt = 0;
    while (!bus.f_st && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("t4_f_st_seen", 32'(bus.f_st), 32'd1);
    cnt = 0;
    while (!bus.rd && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_cycles", 32'(cnt), 32'd16);
    chk("t4_err",  32'(bus.err), 32'd1);
    chk("t4_rd",   32'(bus.rd), 32'd1);
    chk("t4_res",  32'(bus.res), 32'd0);
    chk("t4_f_st", 32'(bus.f_st), 32'd0);
    ch_mute[2] = 1'b0;
    @(negedge clk);
    bus.st = 1'b1;
    @(negedge clk);
    bus.st = 1'b0;
    chk("t4_err_clr", 32'(bus.err), 32'd0);
    cnt = 0;
    while (!bus.rd && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("t4_res2", 32'(bus.res), 32'd40);
    chk("t4_err2", 32'(bus.err), 32'd0);

    // st toggled twice while busy -> one run, first args kept
    set_child(0, 4, 0);
    r0 = runs;
    @(negedge clk);
    bus.st = 1'b1; bus.in0 = 16'd7; bus.in1 = 16'd3;
    @(negedge clk);
    bus.st = 1'b0;
    @(negedge clk);
    bus.st = 1'b1; bus.in0 = 16'd100; bus.in1 = 16'd50;
    @(negedge clk);
    bus.st = 1'b0;
    @(negedge clk);
    bus.st = 1'b1; bus.in0 = 16'd200; bus.in1 = 16'd60;
    @(negedge clk);
    bus.st = 1'b0;
    cnt = 0;
    while (!bus.rd && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("t5_runs", 32'(runs - r0), 32'd1);
    chk("t5_rd",   32'(bus.rd), 32'd1);
    chk("t5_res",  32'(bus.res), 32'd40);
    chk("t5_arg0", 32'(bus.arg0), 32'd7);
    chk("t5_arg1", 32'(bus.arg1), 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
